pool_result_writer: RTL and testbench

- Consumer at the output end of the ReLU/max-pool stage.
- Accepts the stream of pooled samples, one per valid cycle, and packs pairs of samples into double-width words.
- Generates contiguous write addresses into the layer output buffer (BRAM), channel after channel.
- Reports busy, completion and protocol errors to the layer controller.

---
 rtl/pool_result_writer_pkg.sv | 24 ++
 rtl/pool_word_packer.sv | 48 ++++
 rtl/pool_result_writer.sv | 195 +++++++++++++++++++
 tb/tb_pool_result_writer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_result_writer_pkg.sv
// Shared types and sizing for the pooled-result writer: FSM encoding and
// the pooled-sample count derived from the pre-pool feature-map side.
package pool_result_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam int unsigned MAX_POOLED_SIDE = 15;
    localparam int unsigned FMAP_W          = 5;
    localparam int unsigned SIDE_W          = $clog2(MAX_POOLED_SIDE + 1);
    localparam int unsigned SCNT_W          = $clog2(MAX_POOLED_SIDE * MAX_POOLED_SIDE + 1);

    // Samples per channel after 2x2 pooling: (featmap_size/2)^2.
    function automatic logic [SCNT_W-1:0] pooled_count(input logic [FMAP_W-1:0] featmap_size);
        logic [SIDE_W-1:0] side;
        side = SIDE_W'(featmap_size >> 1);
        return SCNT_W'(side) * SCNT_W'(side);
    endfunction

endpackage

// File: rtl/pool_word_packer.sv
// Pairs consecutive samples into one double-width word; a flush emits the
// pending low half padded with zero and may capture a new sample at once.
module pool_word_packer #(
    parameter int unsigned dwidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic                  i_flush,
    input  logic [dwidth-1:0]     i_din,
    output logic [2*dwidth-1:0]   o_word_c,
    output logic                  o_word_vld_c
);

    logic [dwidth-1:0] r_low;
    logic              r_full;
    logic              w_pair;

    always_comb begin
        w_pair       = i_push && r_full && !i_flush;
        o_word_vld_c = w_pair || i_flush;
        o_word_c     = w_pair ? {i_din, r_low} : {{dwidth{1'b0}}, r_low};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_low  <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_low  <= '0;
            r_full <= 1'b0;
        end else if (i_flush) begin
            r_full <= i_push;
            if (i_push) begin
                r_low <= i_din;
            end
        end else if (i_push) begin
            if (r_full) begin
                r_full <= 1'b0;
            end else begin
                r_low  <= i_din;
                r_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_result_writer.sv
// Writes pooled samples, packed two per word, to contiguous output-buffer
// addresses channel after channel; reports busy/done/stray-data to the controller.
module pool_result_writer
    import pool_result_writer_pkg::*;
#(
    parameter int unsigned dwidth = 16,
    parameter int unsigned awidth = 12,
    parameter int unsigned cwidth = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FMAP_W-1:0]     featmap_size,
    input  logic [cwidth-1:0]     ch_num,
    input  logic [awidth-1:0]     base_addr,
    input  logic [dwidth-1:0]     din,
    input  logic                  din_vld,
    output logic                  wr_en,
    output logic [awidth-1:0]     wr_addr,
    output logic [2*dwidth-1:0]   wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SCNT_W-1:0]   r_n;
    logic [cwidth-1:0]   r_ch_num;
    logic [awidth-1:0]   r_addr;
    logic [SCNT_W-1:0]   r_sample_cnt;
    logic [cwidth-1:0]   r_ch_cnt;
    logic [SCNT_W-1:0]   w_sample_cnt_nxt;
    logic [cwidth-1:0]   w_ch_cnt_nxt;
    logic [SCNT_W-1:0]   w_n_start;
    logic                w_accept;
    logic                w_push;
    logic                w_flush;
    logic                w_stray;
    logic                w_sample_last;
    logic                w_ch_last;
    logic [2*dwidth-1:0] w_word;
    logic                w_word_vld;

    logic                r_wr_en;
    logic [awidth-1:0]   r_wr_addr;
    logic [2*dwidth-1:0] r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

    pool_word_packer #(.dwidth(dwidth)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_accept),
        .i_push       (w_push),
        .i_flush      (w_flush),
        .i_din        (din),
        .o_word_c     (w_word),
        .o_word_vld_c (w_word_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_accept         = 1'b0;
        w_push           = 1'b0;
        w_flush          = 1'b0;
        w_stray          = 1'b0;
        w_sample_cnt_nxt = r_sample_cnt;
        w_ch_cnt_nxt     = r_ch_cnt;
        w_n_start        = pooled_count(featmap_size);
        w_sample_last    = (r_sample_cnt == SCNT_W'(r_n - SCNT_W'(1)));
        w_ch_last        = (r_ch_cnt == cwidth'(r_ch_num - cwidth'(1)));

        case (r_state)
            ST_IDLE: begin
                w_stray = din_vld;
                if (start) begin
                    w_accept         = 1'b1;
                    w_sample_cnt_nxt = '0;
                    w_ch_cnt_nxt     = '0;
                    w_state_nxt      = (w_n_start == '0 || ch_num == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (din_vld) begin
                    w_push           = 1'b1;
                    w_sample_cnt_nxt = SCNT_W'(r_sample_cnt + SCNT_W'(1));
                    if (w_sample_last) begin
                        w_sample_cnt_nxt = '0;
                        if (r_n[0]) begin
                            w_state_nxt = ST_FLUSH;
                        end else if (w_ch_last) begin
                            w_state_nxt = ST_FIN;
                        end else begin
                            w_ch_cnt_nxt = cwidth'(r_ch_cnt + cwidth'(1));
                        end
                    end
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                if (w_ch_last) begin
                    // No channel left to own a sample arriving here.
                    w_state_nxt = ST_FIN;
                    w_stray     = din_vld;
                end else begin
                    w_ch_cnt_nxt = cwidth'(r_ch_cnt + cwidth'(1));
                    w_state_nxt  = ST_RUN;
                    if (din_vld) begin
                        w_push = 1'b1;
                        // A one-sample channel ends on its first sample.
                        if (r_n == SCNT_W'(1)) begin
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            w_sample_cnt_nxt = SCNT_W'(1);
                        end
                    end
                end
            end
            ST_FIN: begin
                w_stray     = din_vld;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latched layer configuration, counters and write address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n          <= '0;
            r_ch_num     <= '0;
            r_addr       <= '0;
            r_sample_cnt <= '0;
            r_ch_cnt     <= '0;
        end else begin
            r_sample_cnt <= w_sample_cnt_nxt;
            r_ch_cnt     <= w_ch_cnt_nxt;
            if (w_accept) begin
                r_n      <= w_n_start;
                r_ch_num <= ch_num;
                r_addr   <= base_addr;
            end else if (w_word_vld) begin
                r_addr <= awidth'(r_addr + awidth'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_word_vld;
            if (w_word_vld) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_word;
            end
            r_done <= (r_state == ST_FIN);
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_FIN) begin
                r_busy <= 1'b0;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pool_result_writer.sv
// Self-checking bench for pool_result_writer: table-driven layers, random
// layers against a word/timing reference model, and stray/reset sequences.
`timescale 1ns/1ps
module tb_pool_result_writer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned CW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [4:0]      featmap_size;
    logic [CW-1:0]   ch_num;
    logic [AW-1:0]   base_addr;
    logic [DW-1:0]   din;
    logic            din_vld;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2*DW-1:0] wr_data;
    logic            busy;
    logic            done;
    logic            err;

    pool_result_writer #(.dwidth(DW), .awidth(AW), .cwidth(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .featmap_size (featmap_size),
        .ch_num       (ch_num),
        .base_addr    (base_addr),
        .din          (din),
        .din_vld      (din_vld),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [2*DW-1:0] data;
        int              cyc;
    } wr_t;

    wr_t wq[$];
    int  dq[$];

    // Observed writes and done pulses, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (wr_en) wq.push_back('{wr_addr, wr_data, cyc});
            if (done)  dq.push_back(cyc);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drives one layer and compares every write (address, data, cycle) and
    // the done pulse against words rebuilt from the sample list.
    task automatic run_layer(input int fm, input int ch, input int base,
                             input int gap, input bit rnd, input int restart_at);
        int          n;
        int          t0;
        int          k;
        int          nw;
        int          exp_done;
        logic [DW-1:0] s[$];
        int          dc[$];
        wr_t         ew[$];
        wq.delete();
        dq.delete();
        n = (fm / 2) * (fm / 2);
        @(negedge clk);
        featmap_size = 5'(fm);
        ch_num       = CW'(ch);
        base_addr    = AW'(base);
        start        = 1'b1;
        t0           = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_after_start", err, 0);
        k        = 0;
        exp_done = t0 + 2;
        for (int c = 0; c < ch && n > 0; c++) begin
            s.delete();
            dc.delete();
            for (int i = 0; i < n; i++) begin
                int g;
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                if (c == 0 && i == 0) g = 0;
                repeat (g) begin
                    din_vld = 1'b0;
                    @(negedge clk);
                end
                din     = rnd ? DW'($urandom) : DW'(c * 100 + i + 1);
                din_vld = 1'b1;
                s.push_back(din);
                dc.push_back(cyc);
                if (c * n + i == restart_at) begin
                    start        = 1'b1;
                    featmap_size = 5'd28;
                    ch_num       = CW'(7);
                    base_addr    = AW'('hABC);
                end
                @(negedge clk);
                start = 1'b0;
            end
            for (int w = 0; 2 * w < n; w++) begin
                wr_t e;
                e.addr = AW'(base + k);
                if (2 * w + 1 < n) begin
                    e.data = {s[2*w+1], s[2*w]};
                    e.cyc  = dc[2*w+1] + 1;
                end else begin
                    e.data = {DW'(0), s[2*w]};
                    e.cyc  = dc[2*w] + 2;
                end
                ew.push_back(e);
                k++;
                exp_done = e.cyc + 1;
            end
        end
        din_vld = 1'b0;
        for (int t = 0; t < 8 && dq.size() == 0; t++) @(negedge clk);
        if (dq.size() == 0) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
        chk("nwrites", wq.size(), ew.size());
        nw = (wq.size() < ew.size()) ? wq.size() : ew.size();
        for (int w = 0; w < nw; w++) begin
            chk($sformatf("wr%0d_addr", w), wq[w].addr, ew[w].addr);
            chk($sformatf("wr%0d_data", w), wq[w].data, ew[w].data);
            chk($sformatf("wr%0d_cycle", w), wq[w].cyc, ew[w].cyc);
        end
        chk("done_count", dq.size(), 1);
        if (dq.size() > 0) chk("done_cycle", dq[0], exp_done);
        chk("err_end", err, 0);
        chk("busy_end", busy, 0);
    endtask

    typedef struct {
        int          fm;
        int          ch;
        int          base;
        int          gap;
        int          restart_at;
        int          exp_words;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_last_addr;
    } vec_t;

    vec_t        vecs[7];
    int          widx[3];
    logic [31:0] wval[3];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{28, 1, 'h100, 0, -1, 98, 32'h0002_0001, 32'h00C4_00C3, 'h161};
        vecs[1] = '{10, 2, 'h000, 0, -1, 26, 32'h0002_0001, 32'h0000_007D, 'h019};
        vecs[2] = '{28, 1, 'h100, 2, -1, 98, 32'h0002_0001, 32'h00C4_00C3, 'h161};
        vecs[3] = '{ 1, 3, 'h040, 0, -1,  0, 32'h0,         32'h0,         0};
        vecs[4] = '{20, 0, 'h040, 0, -1,  0, 32'h0,         32'h0,         0};
        vecs[5] = '{10, 1, 'h300, 0,  7, 13, 32'h0002_0001, 32'h0000_0019, 'h30C};
        vecs[6] = '{ 3, 4, 'hFFE, 0, -1,  4, 32'h0000_0001, 32'h0000_012D, 'h001};
        widx = '{12, 13, 25};
        wval = '{32'h0000_0019, 32'h0066_0065, 32'h0000_007D};

        rst          = 1'b1;
        start        = 1'b0;
        featmap_size = '0;
        ch_num       = '0;
        base_addr    = '0;
        din          = '0;
        din_vld      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int v = 0; v < 7; v++) begin
            run_layer(vecs[v].fm, vecs[v].ch, vecs[v].base, vecs[v].gap, 1'b0, vecs[v].restart_at);
            chk($sformatf("tbl%0d_words", v), wq.size(), vecs[v].exp_words);
            if (vecs[v].exp_words > 0 && wq.size() > 0) begin
                chk($sformatf("tbl%0d_first", v), wq[0].data, vecs[v].exp_first);
                chk($sformatf("tbl%0d_last", v), wq[wq.size()-1].data, vecs[v].exp_last);
                chk($sformatf("tbl%0d_last_addr", v), wq[wq.size()-1].addr, vecs[v].exp_last_addr);
            end
            if (v == 1 && wq.size() == 26) begin
                for (int j = 0; j < 3; j++)
                    chk($sformatf("fm10_word%0d", widx[j]), wq[widx[j]].data, wval[j]);
            end
        end

        for (int r = 0; r < 6; r++) begin
            run_layer(int'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4095)), -1, 1'b1, -1);
        end

        // Stray sample while idle.
        wq.delete();
        @(negedge clk);
        din     = 16'h7FFF;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        chk("stray_err", err, 1);
        repeat (2) @(negedge clk);
        chk("stray_err_hold", err, 1);
        chk("stray_nowrite", wq.size(), 0);
        run_layer(10, 1, 'h080, 0, 1'b0, -1);

        // Abort a layer mid-stream with reset, then start fresh.
        for (int a = 50; a <= 51; a++) begin
            @(negedge clk);
            featmap_size = 5'd28;
            ch_num       = CW'(1);
            base_addr    = AW'('h100);
            start        = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < a; i++) begin
                din     = DW'(i + 1);
                din_vld = 1'b1;
                @(negedge clk);
            end
            din_vld = 1'b0;
            chk($sformatf("abort%0d_busy_pre", a), busy, 1);
            rst = 1'b1;
            #1;
            chk($sformatf("abort%0d_wr_en", a), wr_en, 0);
            chk($sformatf("abort%0d_wr_addr", a), wr_addr, 0);
            chk($sformatf("abort%0d_wr_data", a), wr_data, 0);
            chk($sformatf("abort%0d_busy", a), busy, 0);
            chk($sformatf("abort%0d_done", a), done, 0);
            chk($sformatf("abort%0d_err", a), err, 0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            run_layer(28, 1, 'h200, 0, 1'b0, -1);
            if (wq.size() > 0) chk($sformatf("abort%0d_first_addr", a), wq[0].addr, 'h200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
